// File: rtl/regfile_pkg.sv
// Shared types and defaults for the MIPS general-purpose register file.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_t;

endpackage

// File: rtl/param_register_file_if.sv
// Decode/write-back bus for the register file: two read ports, one write port, ready.
interface param_register_file_if #(
   parameter int unsigned DATA_W = regfile_pkg::DEF_DATA_W,
   parameter int unsigned ADDR_W = regfile_pkg::DEF_ADDR_W
) ();

   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [ADDR_W-1:0] rd;
   logic              regWrite;
   logic [DATA_W-1:0] writeData;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;
   logic              ready;

   modport master (
      output rs, rt, rd, regWrite, writeData,
      input  readData1, readData2, ready
   );

   modport slave (
      input  rs, rt, rd, regWrite, writeData,
      output readData1, readData2, ready
   );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: clear masking, hardwired zero, then optional write bypass.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  rf_state_t         state,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data_c
);

   // Priority read selection; the first matching rule wins.
   always_comb begin
      data_c = mem_data;
      if (state == CLEAR) begin
         data_c = '0;
      end else if (ZERO_REG && (addr == '0)) begin
         data_c = '0;
      end else if (BYPASS && wr_en && (wr_addr == addr)) begin
         data_c = wr_data;
      end
   end

endmodule

// File: rtl/param_register_file.sv
// Register file with post-reset clear sequencer, one write port and two read ports.
module param_register_file
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   param_register_file_if.slave  bus
);

   localparam int unsigned       DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   rf_state_t         state;
   rf_state_t         state_nxt;
   logic [ADDR_W-1:0] clr_idx;
   logic [ADDR_W-1:0] clr_idx_nxt;
   logic              clr_en_c;
   logic              wr_en_c;
   logic [DATA_W-1:0] mem [DEPTH];

   // State and clear-index registers; reset restarts the clear sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   // Next state, clear strobe and qualified write enable.
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      clr_en_c    = 1'b0;
      wr_en_c     = 1'b0;
      case (state)
         CLEAR: begin
            clr_en_c = 1'b1;
            if (clr_idx == LAST_IDX) begin
               state_nxt = READY;
            end else begin
               clr_idx_nxt = clr_idx + ADDR_W'(1);
            end
         end
         READY: begin
            wr_en_c = bus.regWrite && !(ZERO_REG && (bus.rd == '0));
         end
         default: begin
            state_nxt = CLEAR;
         end
      endcase
   end

   // Storage: zeroed one entry per cycle while clearing, written from write-back when ready.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_en_c) begin
            mem[clr_idx] <= '0;
         end else if (wr_en_c) begin
            mem[bus.rd] <= bus.writeData;
         end
      end
   end

   assign bus.ready = (state == READY);

   // Read port 1, addressed by rs.
   regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_port1 (
      .state    (state),
      .addr     (bus.rs),
      .mem_data (mem[bus.rs]),
      .wr_addr  (bus.rd),
      .wr_en    (bus.regWrite),
      .wr_data  (bus.writeData),
      .data_c   (bus.readData1)
   );

   // Read port 2, addressed by rt.
   regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_port2 (
      .state    (state),
      .addr     (bus.rt),
      .mem_data (mem[bus.rt]),
      .wr_addr  (bus.rd),
      .wr_en    (bus.regWrite),
      .wr_data  (bus.writeData),
      .data_c   (bus.readData2)
   );

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: three configurations driven by common stimulus.
// a: 32x32, zero reg + bypass; b: 32x32, neither; c: 16-bit x 8, zero reg + bypass.
module tb_param_register_file;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs, rt, rd;
   logic        we;
   logic [31:0] wdata;

   int checks = 0;
   int errors = 0;

   // Reference model state per configuration
   logic [31:0] m_mem [3][32];
   int          m_clr [3];
   int          rdy_cnt [3];

   param_register_file_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
   param_register_file_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
   param_register_file_if #(.DATA_W(16), .ADDR_W(3)) bus_c ();

   assign bus_a.rs = rs;  assign bus_a.rt = rt;  assign bus_a.rd = rd;
   assign bus_a.regWrite = we;  assign bus_a.writeData = wdata;
   assign bus_b.rs = rs;  assign bus_b.rt = rt;  assign bus_b.rd = rd;
   assign bus_b.regWrite = we;  assign bus_b.writeData = wdata;
   assign bus_c.rs = rs[2:0];  assign bus_c.rt = rt[2:0];  assign bus_c.rd = rd[2:0];
   assign bus_c.regWrite = we;  assign bus_c.writeData = wdata[15:0];

   param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a));
   param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b));
   param_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
      .clk(clk), .rst(rst), .bus(bus_c));

   always #5 clk = ~clk;

   function automatic int dep(int k);        return (k == 2) ? 8 : 32; endfunction
   function automatic bit zr(int k);         return (k != 1); endfunction
   function automatic bit bp(int k);         return (k != 1); endfunction
   function automatic logic [31:0] dmask(int k); return (k == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF; endfunction
   function automatic logic [4:0] amask(int k);  return (k == 2) ? 5'd7 : 5'd31; endfunction

   // Expected read value from the rules: clear, zero reg, bypass, stored value.
   function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
      logic [4:0] aa;
      logic [4:0] wa;
      aa = a & amask(k);
      wa = rd & amask(k);
      if (m_clr[k] > 0) return 32'h0;
      if (zr(k) && aa == 5'd0) return 32'h0;
      if (bp(k) && we && wa == aa) return wdata & dmask(k);
      return m_mem[k][aa];
   endfunction

   function automatic logic [31:0] act1(int k);
      case (k)
         0: return bus_a.readData1;
         1: return bus_b.readData1;
         default: return 32'(bus_c.readData1);
      endcase
   endfunction

   function automatic logic [31:0] act2(int k);
      case (k)
         0: return bus_a.readData2;
         1: return bus_b.readData2;
         default: return 32'(bus_c.readData2);
      endcase
   endfunction

   function automatic logic act_ready(int k);
      case (k)
         0: return bus_a.ready;
         1: return bus_b.ready;
         default: return bus_c.ready;
      endcase
   endfunction

   // Advance the model across one rising edge using the inputs present at it.
   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_clr[k] = dep(k);
         end else if (m_clr[k] > 0) begin
            m_clr[k]--;
            if (m_clr[k] == 0)
               for (int i = 0; i < 32; i++) m_mem[k][i] = 32'h0;
         end else if (we && !(zr(k) && (rd & amask(k)) == 5'd0)) begin
            m_mem[k][rd & amask(k)] = wdata & dmask(k);
         end
      end
      #1;
   endtask

   // Count negedge samples with ready low until every configuration is ready (bounded).
   task automatic wait_ready();
      bit all_rdy;
      for (int k = 0; k < 3; k++) rdy_cnt[k] = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         all_rdy = 1'b1;
         for (int k = 0; k < 3; k++) begin
            if (act_ready(k) !== 1'b1) begin
               rdy_cnt[k]++;
               all_rdy = 1'b0;
            end
         end
         if (all_rdy) break;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; we = 1'b0; rs = 5'd1; rt = 5'd2; rd = 5'd0; wdata = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks += 3;
         if (act_ready(k) !== 1'b0) begin
            errors++; $display("FAIL reset_ready cfg%0d got %b want 0", k, act_ready(k));
         end
         if (act1(k) !== 32'h0) begin
            errors++; $display("FAIL reset_rd1 cfg%0d got %h want 0", k, act1(k));
         end
         if (act2(k) !== 32'h0) begin
            errors++; $display("FAIL reset_rd2 cfg%0d got %h want 0", k, act2(k));
         end
      end
      wait_ready();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rdy_cnt[k] != dep(k)) begin
            errors++; $display("FAIL reset_latency cfg%0d got %0d want %0d", k, rdy_cnt[k], dep(k));
         end
      end
      tick();
   endtask

   task automatic test_clear_fill();
      we = 1'b1; wdata = 32'hDEAD_BEEF;
      for (int a = 0; a < 32; a++) begin
         rd = 5'(a);
         tick();
      end
      we = 1'b0; rs = 5'd9; rt = 5'd31;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (act1(k) !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL fill cfg%0d got %h want deadbeef", k, act1(k));
         end
      end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rdy_cnt[k] != dep(k)) begin
            errors++; $display("FAIL clear_latency cfg%0d got %0d want %0d", k, rdy_cnt[k], dep(k));
         end
      end
      tick();
      for (int a = 0; a < 32; a++) begin
         rs = 5'(a); rt = 5'(31 - a);
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            checks += 2;
            if (act1(k) !== 32'h0) begin
               errors++; $display("FAIL cleared_rd1 cfg%0d addr %0d got %h want 0", k, a, act1(k));
            end
            if (act2(k) !== 32'h0) begin
               errors++; $display("FAIL cleared_rd2 cfg%0d addr %0d got %h want 0", k, 31 - a, act2(k));
            end
         end
         tick();
      end
   endtask

   task automatic test_write_read();
      rd = 5'd5; wdata = 32'h1234_5678; we = 1'b1;
      tick();
      we = 1'b0; rs = 5'd5; rt = 5'd5;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks += 2;
         if (act1(k) !== (32'h1234_5678 & dmask(k))) begin
            errors++; $display("FAIL write_read_rd1 cfg%0d got %h want %h", k, act1(k), 32'h1234_5678 & dmask(k));
         end
         if (act2(k) !== (32'h1234_5678 & dmask(k))) begin
            errors++; $display("FAIL write_read_rd2 cfg%0d got %h want %h", k, act2(k), 32'h1234_5678 & dmask(k));
         end
      end
      tick();
   endtask

   task automatic test_zero_reg();
      rd = 5'd0; wdata = 32'hFFFF_FFFF; we = 1'b1; rs = 5'd0; rt = 5'd0;
      @(negedge clk);
      checks += 3;
      if (act1(0) !== 32'h0) begin
         errors++; $display("FAIL zero_during cfg0 got %h want 0", act1(0));
      end
      if (act1(2) !== 32'h0) begin
         errors++; $display("FAIL zero_during cfg2 got %h want 0", act1(2));
      end
      if (act1(1) !== exp_rd(1, rs)) begin
         errors++; $display("FAIL zero_during cfg1 got %h want %h", act1(1), exp_rd(1, rs));
      end
      tick();
      we = 1'b0;
      @(negedge clk);
      checks += 3;
      if (act1(0) !== 32'h0) begin
         errors++; $display("FAIL zero_after cfg0 got %h want 0", act1(0));
      end
      if (act2(2) !== 32'h0) begin
         errors++; $display("FAIL zero_after cfg2 got %h want 0", act2(2));
      end
      if (act1(1) !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL zero_after cfg1 got %h want ffffffff", act1(1));
      end
      tick();
   endtask

   task automatic test_bypass();
      rd = 5'd7; wdata = 32'hA; we = 1'b1; rs = 5'd0;
      tick();
      wdata = 32'hB; rs = 5'd7;
      @(negedge clk);
      checks += 3;
      if (act1(0) !== 32'hB) begin
         errors++; $display("FAIL bypass_on cfg0 got %h want b", act1(0));
      end
      if (act1(2) !== 32'hB) begin
         errors++; $display("FAIL bypass_on cfg2 got %h want b", act1(2));
      end
      if (act1(1) !== 32'hA) begin
         errors++; $display("FAIL bypass_off cfg1 got %h want a", act1(1));
      end
      tick();
      we = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (act1(k) !== 32'hB) begin
            errors++; $display("FAIL bypass_next cfg%0d got %h want b", k, act1(k));
         end
      end
      tick();
   endtask

   task automatic test_reset_mid_clear();
      rst = 1'b1;
      tick();
      rst = 1'b0; we = 1'b1; rd = 5'd3; wdata = 32'h55; rs = 5'd3; rt = 5'd3;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (act1(0) !== 32'h0) begin
            errors++; $display("FAIL midclear_rd cfg0 cyc %0d got %h want 0", i, act1(0));
         end
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready();
      we = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks += 2;
         if (rdy_cnt[k] != dep(k)) begin
            errors++; $display("FAIL midclear_latency cfg%0d got %0d want %0d", k, rdy_cnt[k], dep(k));
         end
         if (act1(k) !== exp_rd(k, rs)) begin
            errors++; $display("FAIL midclear_entry3 cfg%0d got %h want %h", k, act1(k), exp_rd(k, rs));
         end
      end
      checks += 2;
      if (act1(0) !== 32'h0) begin
         errors++; $display("FAIL midclear_zero cfg0 got %h want 0", act1(0));
      end
      if (act2(1) !== 32'h0) begin
         errors++; $display("FAIL midclear_zero cfg1 got %h want 0", act2(1));
      end
      tick();
   endtask

   task automatic test_param_sweep();
      rd = 5'd7; wdata = 32'h0000_BEEF; we = 1'b1;
      tick();
      we = 1'b0; rs = 5'd7; rt = 5'd7;
      @(negedge clk);
      checks += 2;
      if (act1(2) !== 32'h0000_BEEF) begin
         errors++; $display("FAIL sweep_rd1 cfg2 got %h want beef", act1(2));
      end
      if (act2(2) !== 32'h0000_BEEF) begin
         errors++; $display("FAIL sweep_rd2 cfg2 got %h want beef", act2(2));
      end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
         if ($urandom_range(3) == 0) rd = rs;
         if ($urandom_range(5) == 0) rd = 5'd0;
         we = 1'($urandom); wdata = $urandom;
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            checks += 2;
            if (act1(k) !== exp_rd(k, rs)) begin
               errors++; $display("FAIL random_rd1 cfg%0d iter %0d got %h want %h", k, i, act1(k), exp_rd(k, rs));
            end
            if (act2(k) !== exp_rd(k, rt)) begin
               errors++; $display("FAIL random_rd2 cfg%0d iter %0d got %h want %h", k, i, act2(k), exp_rd(k, rt));
            end
         end
         tick();
      end
      we = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) m_clr[k] = dep(k);
      test_reset();
      test_clear_fill();
      test_write_read();
      test_zero_reg();
      test_bypass();
      test_reset_mid_clear();
      test_param_sweep();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised general-purpose register file for the MIPS datapath: two asynchronous read ports, one synchronous write port, optional hardwired-zero register 0, and optional write-to-read bypass. After reset a clear sequencer zeroes every entry, one per cycle, and holds `ready` low until it finishes. It sits between decode (read ports) and write-back (write port), and `ready` gates pipeline start-up.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; `DEPTH = 2**ADDR_W` entries.
- `ZERO_REG`, 1: when 1, entry 0 reads as zero and writes to it are dropped.
- `BYPASS`, 1: when 1, a same-cycle write to a register being read is forwarded to the read port.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset; it starts the clear sequence.
- `rs` input ADDR_W: read address, port 1.
- `rt` input ADDR_W: read address, port 2.
- `rd` input ADDR_W: write address.
- `regWrite` input 1: write enable.
- `writeData` input DATA_W: write data.
- `readData1` output DATA_W: port 1 data, combinational from `rs`.
- `readData2` output DATA_W: port 2 data, combinational from `rt`.
- `ready` output 1: high once the clear sequence is complete.

## Operation
- State machine states: CLEAR, READY.
- On any edge with `rst` = 1:
  - state goes to CLEAR and `clrIdx` goes to 0.
  - Storage is not touched on that edge.
- CLEAR state, on an edge with `rst` = 0:
  - `mem[clrIdx]` is set to 0 and `clrIdx` increments.
  - When `clrIdx == DEPTH-1`, that entry is zeroed and state goes to READY.
  - `regWrite` is ignored throughout CLEAR.
- READY state, on an edge with `regWrite` = 1:
  - `mem[rd]` is set to `writeData`.
  - Exception: if `ZERO_REG` = 1 and `rd` = 0, the write is dropped.
- Read rule for port 1 (port 2 is identical with `rt`), first match wins:
  1. In CLEAR: the result is 0.
  2. If `ZERO_REG` = 1 and `rs` = 0: the result is 0.
  3. If `BYPASS` = 1, state is READY, `regWrite` = 1 and `rd == rs`: the result is `writeData`.
  4. Otherwise: the result is `mem[rs]`.
- Reads are purely combinational on the addresses, the current state and the write inputs. There is no read latency.
- Both read ports may address the same entry, and both may match the bypass in the same cycle.
- Width rules:
  - `clrIdx` is ADDR_W bits wide and never wraps; the transition happens at DEPTH-1.
  - Addresses always index in range, so there is no out-of-bounds handling.

## Timing
- Reset values, valid from the first edge with `rst` = 1 onward:
  - `ready` = 0.
  - `readData1` and `readData2` = 0.
  - state = CLEAR, `clrIdx` = 0.
- Clear latency: `rst` is sampled high at edge E0 and low from E1 on. Edges E1 through E_DEPTH clear entries 0 through DEPTH-1. `ready` rises immediately after E_DEPTH, i.e. DEPTH cycles after reset deasserts (32 cycles by default).
- Reset asserted in the middle of the clear sequence: the sequence restarts with `clrIdx` = 0 and `ready` stays 0.
- Reset asserted while in READY: `ready` drops right after that edge, and the full clear runs again.
- Write timing:
  - A write on edge N is visible through the plain read path from after edge N.
  - With `BYPASS` = 1, the write is also visible during cycle N-1, while `regWrite` is asserted.
  - With `BYPASS` = 0, a read of `rd` in the same cycle as its write returns the old value.
- The first write accepted is on the edge after `ready` rises. A write presented in the cycle where `ready` is still 0 is dropped.

## Structure
- Shared package `regfile_pkg`:
  - state enum `rf_state_t` with values CLEAR and READY.
  - constants for default `DATA_W` and `ADDR_W`.
- Sub-module `regfile_read_port`:
  - one instance per read port, implementing the four-step read rule.
  - parameters: `DATA_W`, `ADDR_W`, `ZERO_REG`, `BYPASS`.
- The top level holds the storage array, the clear FSM, the write logic and two `regfile_read_port` instances.

## Test plan
- Reset clear: first fill entries with 32'hDEAD_BEEF, then pulse `rst` for 1 cycle. Required: `ready` = 0 for exactly 32 cycles, then 1. Every `rs` from 0 to 31 then reads 0.
- Write then read: write `rd` = 5 with 32'h1234_5678, then read `rs` = 5 and `rt` = 5 on the next cycle. Required: both ports return 32'h1234_5678.
- Zero register: with `ZERO_REG` = 1, write `rd` = 0 with 32'hFFFF_FFFF. Required: `rs` = 0 returns 0, both during the write cycle and after it.
- Bypass: entry 7 holds 32'hA. Write `rd` = 7 with 32'hB while `rs` = 7.
  - `BYPASS` = 1: `readData1` = 32'hB in that cycle.
  - `BYPASS` = 0: `readData1` = 32'hA in that cycle and 32'hB in the next.
- Reset mid-clear: assert `rst` again 10 cycles into a clear, while holding `regWrite` = 1 with `rd` = 3 and data 32'h55. Required: `ready` rises 32 cycles after the second reset deasserts, and entry 3 reads 0.
- Parameter sweep with `DATA_W` = 16 and `ADDR_W` = 3. Required: `ready` rises after 8 cycles. A write of 16'hBEEF to entry 7 reads back 16'hBEEF.
